// File: rtl/snake_layer_compositor.sv
// Snake layer compositor: walks the segment table into LANES body lanes each
// frame and composites startup/head/food/body layers through a 2-stage pixel pipe.
// Optional build macro: SNAKE_BODY_SHADE_EN (dimmer colour for the tail half of the body).
module snake_layer_compositor #(
  parameter int MAX_LEN = 64,
  parameter int LANES   = 32,
  parameter int COORD_W = 10,
  parameter int HEAD_R  = 16,
  parameter int FOOD_R  = 16,
  parameter int BODY_R  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pixel_en,
  input  logic [COORD_W-1:0]           pixel_x,
  input  logic [COORD_W-1:0]           pixel_y,
  input  logic                         frame_start,
  input  logic [1:0]                   mode,
  input  logic [$clog2(MAX_LEN+1)-1:0] snake_len,
  input  logic [COORD_W-1:0]           head_x,
  input  logic [COORD_W-1:0]           head_y,
  input  logic [COORD_W-1:0]           food_x,
  input  logic [COORD_W-1:0]           food_y,
  input  logic                         has_food,
  input  logic [7:0]                   startup_pix,
  input  logic [7:0]                   head_pix,
  input  logic [7:0]                   food_pix,
  output logic                         seg_rd_en,
  output logic [$clog2(MAX_LEN)-1:0]   seg_rd_addr,
  input  logic [COORD_W-1:0]           seg_rd_x,
  input  logic [COORD_W-1:0]           seg_rd_y,
  output logic                         busy,
  output logic                         pixel_valid,
  output logic [7:0]                   pixel_rgb
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SUM_W  = 2 * COORD_W + 2;

  localparam logic [SUM_W-1:0]  HEAD_R2   = SUM_W'(HEAD_R * HEAD_R);
  localparam logic [SUM_W-1:0]  FOOD_R2   = SUM_W'(FOOD_R * FOOD_R);
  localparam logic [SUM_W-1:0]  BODY_R2   = SUM_W'(BODY_R * BODY_R);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [7:0] BODY_BRIGHT = 8'b000_11_000;
`ifdef SNAKE_BODY_SHADE_EN
  localparam logic [7:0] BODY_DIM    = 8'b000_10_000;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

  // Differences are taken at full sum width so edge-of-screen points never wrap.
  function automatic logic hit(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                               input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                               input logic [SUM_W-1:0] r2);
    logic signed [SUM_W-1:0] dx;
    logic signed [SUM_W-1:0] dy;
    logic [SUM_W-1:0]        dist2;
    dx    = $signed(SUM_W'(ax)) - $signed(SUM_W'(bx));
    dy    = $signed(SUM_W'(ay)) - $signed(SUM_W'(by));
    dist2 = $unsigned(dx * dx) + $unsigned(dy * dy);
    return dist2 <= r2;
  endfunction

  state_t              r_state;
  state_t              w_state_nx;
  logic [LEN_W-1:0]    r_len_q;
  logic [ADDR_W-1:0]   r_base;
  logic                r_seg_rd_en;
  logic [ADDR_W-1:0]   r_seg_rd_addr;
  logic [LANE_W-1:0]   r_rd_lane;
  logic                r_cap_en;
  logic [LANE_W-1:0]   r_cap_lane;
  logic [LANES-1:0]    r_lane_vld;
  logic [COORD_W-1:0]  r_lane_x [LANES];
  logic [COORD_W-1:0]  r_lane_y [LANES];
`ifdef SNAKE_BODY_SHADE_EN
  logic [ADDR_W-1:0]   r_cap_idx;
  logic [ADDR_W-1:0]   r_lane_idx [LANES];
  logic                w_body_near;
  logic                r_s1_near;
`endif

  logic                w_load_done;
  logic [ADDR_W-1:0]   w_base_start;
  logic [ADDR_W-1:0]   w_base_next;
  logic [ADDR_W-1:0]   w_next_idx;
  logic                w_body_hit;

  logic                r_s1_vld;
  logic                r_s1_init;
  logic                r_s1_head;
  logic                r_s1_food;
  logic                r_s1_body;
  logic [7:0]          r_s1_startup;
  logic [7:0]          r_s1_head_pix;
  logic [7:0]          r_s1_food_pix;
  logic [7:0]          w_rgb;
  logic                r_pixel_valid;
  logic [7:0]          r_pixel_rgb;

  // A base left beyond a shrunken snake restarts the walk at segment 1.
  assign w_base_start = (32'(r_base) >= 32'(snake_len)) ? ADDR_W'(1) : r_base;
  assign w_base_next  = (32'(r_base) + 32'(LANES) >= 32'(r_len_q)) ? ADDR_W'(1)
                                                                    : ADDR_W'(32'(r_base) + 32'(LANES));
  assign w_next_idx   = (32'(r_seg_rd_addr) + 32'd1 >= 32'(r_len_q)) ? ADDR_W'(1)
                                                                      : r_seg_rd_addr + ADDR_W'(1);
  assign w_load_done  = (r_state == S_LOAD) && r_cap_en && (r_cap_lane == LAST_LANE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    if (frame_start)      w_state_nx = (snake_len > LEN_W'(1)) ? S_LOAD : S_ACTIVE;
    else if (w_load_done) w_state_nx = S_ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_len_q       <= '0;
      r_base        <= ADDR_W'(1);
      r_seg_rd_en   <= 1'b0;
      r_seg_rd_addr <= '0;
      r_rd_lane     <= '0;
      r_cap_en      <= 1'b0;
      r_cap_lane    <= '0;
      r_lane_vld    <= '0;
    end else if (frame_start) begin
      // Restart drops any read still in flight; base moves only on a completed load.
      r_len_q    <= snake_len;
      r_lane_vld <= '0;
      r_cap_en   <= 1'b0;
      r_rd_lane  <= '0;
      if (snake_len > LEN_W'(1)) begin
        r_seg_rd_en   <= 1'b1;
        r_seg_rd_addr <= w_base_start;
        r_base        <= w_base_start;
      end else begin
        r_seg_rd_en   <= 1'b0;
      end
    end else begin
      r_cap_en   <= r_seg_rd_en;
      r_cap_lane <= r_rd_lane;
      if (r_seg_rd_en) begin
        if (r_rd_lane == LAST_LANE) begin
          r_seg_rd_en <= 1'b0;
        end else begin
          r_rd_lane     <= r_rd_lane + LANE_W'(1);
          r_seg_rd_addr <= w_next_idx;
        end
      end
      if (r_cap_en) r_lane_vld[r_cap_lane] <= 1'b1;
      if (w_load_done) r_base <= w_base_next;
    end
  end

  // NOTE: lane storage is not reset; the valid bits alone decide whether a lane is used.
  always_ff @(posedge clock) begin
`ifdef SNAKE_BODY_SHADE_EN
    r_cap_idx <= r_seg_rd_addr;
`endif
    if (r_cap_en) begin
      r_lane_x[r_cap_lane]   <= seg_rd_x;
      r_lane_y[r_cap_lane]   <= seg_rd_y;
`ifdef SNAKE_BODY_SHADE_EN
      r_lane_idx[r_cap_lane] <= r_cap_idx;
`endif
    end
  end

  always_comb begin
    w_body_hit  = 1'b0;
`ifdef SNAKE_BODY_SHADE_EN
    w_body_near = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      if (r_lane_vld[i] && hit(pixel_x, pixel_y, r_lane_x[i], r_lane_y[i], BODY_R2)) begin
        w_body_hit = 1'b1;
`ifdef SNAKE_BODY_SHADE_EN
        if (32'(r_lane_idx[i]) <= 32'(r_len_q) / 32'd2) w_body_near = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld      <= 1'b0;
      r_s1_init     <= 1'b0;
      r_s1_head     <= 1'b0;
      r_s1_food     <= 1'b0;
      r_s1_body     <= 1'b0;
      r_s1_startup  <= '0;
      r_s1_head_pix <= '0;
      r_s1_food_pix <= '0;
`ifdef SNAKE_BODY_SHADE_EN
      r_s1_near     <= 1'b0;
`endif
    end else begin
      r_s1_vld <= pixel_en;
      if (pixel_en) begin
        r_s1_init     <= (mode == 2'd0);
        r_s1_head     <= hit(pixel_x, pixel_y, head_x, head_y, HEAD_R2);
        r_s1_food     <= has_food && hit(pixel_x, pixel_y, food_x, food_y, FOOD_R2);
        r_s1_body     <= w_body_hit && (r_len_q > LEN_W'(1));
        r_s1_startup  <= startup_pix;
        r_s1_head_pix <= head_pix;
        r_s1_food_pix <= food_pix;
`ifdef SNAKE_BODY_SHADE_EN
        r_s1_near     <= w_body_near;
`endif
      end
    end
  end

  always_comb begin
    w_rgb = 8'h00;
    if (r_s1_init)      w_rgb = r_s1_startup;
    else if (r_s1_head) w_rgb = r_s1_head_pix;
    else if (r_s1_food) w_rgb = r_s1_food_pix;
    else if (r_s1_body) begin
`ifdef SNAKE_BODY_SHADE_EN
      w_rgb = r_s1_near ? BODY_BRIGHT : BODY_DIM;
`else
      w_rgb = BODY_BRIGHT;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pixel_valid <= 1'b0;
      r_pixel_rgb   <= 8'hFF;
    end else begin
      r_pixel_valid <= r_s1_vld;
      if (r_s1_vld) r_pixel_rgb <= w_rgb;
    end
  end

  // The read strobe is gated by reset so an aborted load issues nothing more.
  assign seg_rd_en   = r_seg_rd_en & ~reset;
  assign seg_rd_addr = r_seg_rd_addr;
  assign busy        = (r_state == S_LOAD);
  assign pixel_valid = r_pixel_valid;
  assign pixel_rgb   = r_pixel_rgb;

endmodule
